// File: rtl/mux4to1_rr_pkg.sv
// mux4to1_rr_pkg: lane count and select encoding shared with the 1:4 demux
package mux4to1_rr_pkg;
  localparam int SEL_W = 2;
  localparam int NLANES = 4;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux4to1_rr_arb4.sv
// rr_arb4: combinational round-robin priority rotator starting after the last grant
module rr_arb4
  import mux4to1_rr_pkg::*;
(
  input  logic [NLANES-1:0] req,
  input  sel_t              last,
  output logic [NLANES-1:0] gnt_onehot,
  output sel_t              gnt_idx,
  output logic              any
);
  sel_t c;
  always_comb begin
    gnt_idx = last;
    any = 1'b0;
    c = last;
    for (int i = NLANES; i >= 1; i--) begin
      c = last + sel_t'(i);
      if (req[c]) begin
        gnt_idx = c;
        any = 1'b1;
      end
    end
    gnt_onehot = any ? (4'b0001 << gnt_idx) : '0;
  end
endmodule

// File: rtl/mux4to1_rr.sv
// mux4to1_rr: round-robin 4:1 stream merge into a registered, source-tagged output
module mux4to1_rr
  import mux4to1_rr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NLANES-1:0] in_valid,
  input  logic [NLANES*W-1:0] in_data,
  output logic [NLANES-1:0] in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output sel_t              out_sel,
  input  logic              out_ready
);
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q, out_data_d;
  sel_t              out_sel_q, out_sel_d, last_q, last_d;
  logic [NLANES-1:0] gnt_onehot;
  sel_t              gnt_idx;
  logic              any, load_ok, take;

  rr_arb4 u_arb (
    .req        (in_valid),
    .last       (last_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  // consume and reload may coincide, so a draining register never bubbles
  assign load_ok = !out_valid_q || out_ready;
  assign take = load_ok && any;
  assign in_ready = (rst_n && load_ok) ? gnt_onehot : '0;
  assign out_valid_d = load_ok ? any : out_valid_q;
  assign out_data_d = take ? in_data[gnt_idx*W +: W] : out_data_q;
  assign out_sel_d = take ? gnt_idx : out_sel_q;
  assign last_d = take ? gnt_idx : last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
      last_q <= sel_t'(NLANES - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      last_q <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
endmodule

// File: tb/tb_mux4to1_rr.sv
// tb_mux4to1_rr: directed self-checking bench for the round-robin 4:1 merge
module tb_mux4to1_rr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
  int n_chk = 0;
  int n_fail = 0;

  mux4to1_rr #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_sel"}, 32'(out_sel), 32'(s));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 4'b0000;
    in_data = 32'h0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ready", 32'(in_ready), 0);
    end
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_ready", 32'(in_ready), 0);
    end
    // single lane 2
    in_valid = 4'b0100;
    in_data = 32'h00A5_0000;
    #1 chk("single_ready", 32'(in_ready), 32'h4);
    tick();
    in_valid = 4'b0000;
    chk_out("single", 1'b1, 8'hA5, 2'd2);
    tick();
    chk("single_drop", 32'(out_valid), 0);
    // pulse reset so lane 0 leads again
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    // full contention
    in_valid = 4'b1111;
    in_data = 32'h1312_1110;
    for (int i = 0; i < 8; i++) begin
      #1 chk("rr_ready", 32'(in_ready), 32'(4'b0001 << (i % 4)));
      tick();
      chk_out("rr", 1'b1, 8'(8'h10 + i % 4), 2'(i % 4));
    end
    // backpressure with lanes 1 and 3
    in_valid = 4'b1010;
    in_data = 32'h2300_2100;
    #1 chk("bp_first_ready", 32'(in_ready), 32'h2);
    tick();
    out_ready = 1'b0;
    chk_out("bp_first", 1'b1, 8'h21, 2'd1);
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 32'(in_ready), 0);
      tick();
      chk_out("bp_hold", 1'b1, 8'h21, 2'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'h8);
    tick();
    chk_out("bp_next", 1'b1, 8'h23, 2'd3);
    // mid-operation reset while holding lane 2
    in_valid = 4'b1111;
    in_data = 32'h3332_3130;
    tick();
    tick();
    tick();
    chk_out("pre_rst", 1'b1, 8'h32, 2'd2);
    rst_n = 1'b0;
    #1 chk("mid_rst_ready", 32'(in_ready), 0);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 32'(in_ready), 32'h1);
    tick();
    chk_out("post_rst", 1'b1, 8'h30, 2'd0);
    // drain lane 0
    in_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'(8'h40 + k);
      tick();
      chk_out("drain", 1'b1, 8'(8'h40 + k), 2'd0);
    end
    in_valid = 4'b0000;
    tick();
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_ready", 32'(in_ready), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
